csa_accum_sched: RTL and testbench

//  Sequencing controller for a 4:2 carry-save compressor that sums a burst of N operands.

---
 rtl/csa_accum_sched.sv | 122 ++++++++++++
 tb/tb_csa_accum_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_sched.sv
// Burst summing controller: folds two operands per beat into a registered carry-save
// pair through one 4:2 compressor, then resolves the pair with a single adder.
module csa_accum_sched #(
    parameter int WIDTH   = 24,
    parameter int MAX_OPS = 32,
    localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [1:0]       state;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] c_reg;
    logic [CNT_W-1:0] remaining;

    logic             beat;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] fa_sum;
    logic [WIDTH-2:0] fa_carry;
    logic [WIDTH-1:0] carry_in;
    logic [WIDTH-1:0] csa_sum;
    logic [WIDTH-2:0] csa_carry;
    logic [CNT_W-1:0] remaining_next;

    // Outputs decode from state only, so nothing on the input ports reaches them combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && in_ready;

    // 4:2 compressor as two chained full-adder rows; carries crossing the top bit are
    // dropped since all arithmetic is mod 2^WIDTH.
    always_comb begin
        b_eff          = (remaining == ONE) ? '0 : in_b;
        fa_sum         = in_a ^ b_eff ^ s_reg;
        fa_carry       = (in_a[WIDTH-2:0] & b_eff[WIDTH-2:0])
                       | (in_a[WIDTH-2:0] & s_reg[WIDTH-2:0])
                       | (b_eff[WIDTH-2:0] & s_reg[WIDTH-2:0]);
        carry_in       = {fa_carry, 1'b0};
        csa_sum        = fa_sum ^ c_reg ^ carry_in;
        csa_carry      = (fa_sum[WIDTH-2:0] & c_reg[WIDTH-2:0])
                       | (fa_sum[WIDTH-2:0] & carry_in[WIDTH-2:0])
                       | (c_reg[WIDTH-2:0] & carry_in[WIDTH-2:0]);
        remaining_next = (remaining >= TWO) ? (remaining - TWO) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            remaining <= '0;
            out_sum   <= '0;
        end else if (abort) begin
            // Abort cancels any active burst and also suppresses a start issued in IDLE.
            if (state != IDLE) begin
                state     <= IDLE;
                s_reg     <= '0;
                c_reg     <= '0;
                remaining <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_count != '0) begin
                            remaining <= (op_count > MAX_CNT) ? MAX_CNT : op_count;
                            s_reg     <= '0;
                            c_reg     <= '0;
                            state     <= ACCUM;
                        end else begin
                            out_sum <= '0;
                            state   <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        s_reg     <= csa_sum;
                        c_reg     <= {csa_carry, 1'b0};
                        remaining <= remaining_next;
                        if (remaining_next == '0) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum <= s_reg + c_reg;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_sched.sv
// Randomized scoreboard bench for csa_accum_sched: the driver queues the expected burst
// total computed by plain addition, and a negedge monitor checks every presented result.
module tb_csa_accum_sched;

    localparam int WIDTH   = 24;
    localparam int MAX_OPS = 32;
    localparam int CNT_W   = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] ops[64];
    bit               rand_start = 1'b0;

    csa_accum_sched #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op_count (op_count),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: the burst total is just the sum of the first N operands, mod 2^WIDTH.
    function automatic logic [WIDTH-1:0] sumModel(input int eff);
        logic [63:0] total;
        total = '0;
        for (int i = 0; i < eff; i++) total += 64'(ops[i]);
        return total[WIDTH-1:0];
    endfunction

    // Monitor: any presented result must match the oldest expected total.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("out_sum", {8'b0, out_sum}, {8'b0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int n);
        int eff;
        int beats;
        int idx;
        int cyc;
        bit done;
        bit acc;
        bit hs;
        eff = (n > MAX_OPS) ? MAX_OPS : n;
        exp_q.push_back(sumModel(eff));
        start    = 1'b1;
        op_count = CNT_W'(n);
        @(posedge clock); #1;
        start = 1'b0;
        beats = 0; idx = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = (idx < eff) ? ops[idx] : WIDTH'($urandom);
            in_b      = (idx + 1 < eff) ? ops[idx+1] : WIDTH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (rand_start) begin
                start    = ($urandom_range(0, 3) == 0);
                op_count = CNT_W'($urandom);
            end
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            @(posedge clock); #1;
            if (acc) begin
                beats++;
                idx += 2;
            end
            if (hs) done = 1'b1;
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("handshake_seen", 32'(done), 32'd1);
        checkOutput("beats_accepted", beats, (eff + 1) / 2);
        checkOutput("busy_after_handshake", 32'(busy), 32'd0);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_count = '0; in_a = '0; in_b = '0;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_sum", {8'b0, out_sum}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] async reset during ACCUM");
        start = 1'b1; op_count = 6'd6;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("accum_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = 24'd5; in_b = 24'd6;
        @(posedge clock); #1;
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_out_sum", {8'b0, out_sum}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] directed bursts");
        ops[0] = 24'd1; ops[1] = 24'd2; ops[2] = 24'd3; ops[3] = 24'd4;
        applyStimulus(4);
        ops[0] = 24'd5; ops[1] = 24'd7; ops[2] = 24'd9;
        applyStimulus(3);
        ops[0] = 24'hFFFFFF; ops[1] = 24'h000002;
        applyStimulus(2);
        for (int i = 0; i < 32; i++) ops[i] = 24'h800000;
        applyStimulus(32);

        $display("[TB] result held under backpressure");
        exp_q.push_back(24'd7);
        start = 1'b1; op_count = 6'd2;
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 24'd3; in_b = 24'd4; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        checkOutput("hold_out_valid_rise", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            start    = (k == 2);
            op_count = 6'd5;
            @(posedge clock); #1;
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_out_sum", {8'b0, out_sum}, 32'd7);
        end
        start = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_busy", 32'(busy), 32'd0);
        checkOutput("release_queue", exp_q.size(), 32'd0);
        exp_q.delete();

        $display("[TB] abort handling");
        start = 1'b1; op_count = 6'd6;
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 24'h123456; in_b = 24'h654321;
        @(posedge clock); #1;
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);
        start = 1'b1; abort = 1'b1; op_count = 6'd4;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("abort_beats_start", 32'(busy), 32'd0);
        applyStimulus(0);
        for (int i = 0; i < 64; i++) ops[i] = WIDTH'($urandom);
        applyStimulus(40);

        $display("[TB] randomized bursts");
        rand_start = 1'b1;
        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < 64; i++) ops[i] = WIDTH'($urandom);
            applyStimulus($urandom_range(0, 40));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        rand_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
